// File: rtl/dualshock_responder.sv
// dualshock_responder: controller-side emulation of a DualShock digital-mode poll.
// Host pins (ATT/CLK/CMD) are synchronized into clk. Each byte is shifted LSB first:
// reply bits change on host CLK falls and command bits are captured on host CLK rises.
// Every byte except the last and any rejected header byte is followed by an ACK pulse.
module dualshock_responder #(
  parameter int ACK_DELAY = 100,
  parameter int ACK_WIDTH = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pad_buttons,
  input  logic        psx_att_n,
  input  logic        psx_clk,
  input  logic        psx_cmd,
  output logic        psx_dat,
  output logic        psx_ack_n,
  output logic        poll_done
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // ACK_WAIT is left on the cycle whose count equals DELAY_LAST, so that the falling
  // edge of psx_ack_n lands exactly ACK_DELAY cycles after the completing rise strobe.
  localparam logic [CW-1:0] DELAY_LAST = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] WIDTH_LAST = CW'(ACK_WIDTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  // Synchronizer reset values per pin {cmd, clk, att}. ATT resets low, so a reset
  // released while ATT is already low never produces a fall strobe; only a fresh
  // high-then-low excursion of ATT can start a transaction.
  localparam logic [2:0] SYNC_INIT = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ACK_WAIT,
    S_ACK_LOW,
    S_IGNORE
  } state_t;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;

  assign pin_raw = {psx_cmd, psx_clk, psx_att_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer for one asynchronous host pin.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  logic att_prev_reg;
  logic clk_prev_reg;
  logic att_fall;
  logic att_rise;
  logic clk_fall;
  logic clk_rise;
  logic cmd_bit;

  // Delayed copies of synchronized ATT and CLK used for edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_prev_reg <= 1'b0;
      clk_prev_reg <= 1'b1;
    end else begin
      att_prev_reg <= pin_sync[0];
      clk_prev_reg <= pin_sync[1];
    end
  end

  assign att_fall = att_prev_reg & ~pin_sync[0];
  assign att_rise = ~att_prev_reg & pin_sync[0];
  assign clk_fall = clk_prev_reg & ~pin_sync[1];
  assign clk_rise = ~clk_prev_reg & pin_sync[1];
  assign cmd_bit  = pin_sync[2];

  state_t        state_reg,     state_next;
  logic [2:0]    bit_cnt_reg,   bit_cnt_next;
  logic [2:0]    byte_idx_reg,  byte_idx_next;
  logic [7:0]    rx_byte_reg,   rx_byte_next;
  logic [15:0]   snap_reg,      snap_next;
  logic [CW-1:0] cnt_reg,       cnt_next;
  logic          dat_reg,       dat_next;
  logic          ack_n_reg,     ack_n_next;
  logic          poll_done_reg, poll_done_next;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_full;
  logic          header_bad;

  // Reply byte for the current byte index; button bytes come from the snapshot only.
  always_comb begin
    tx_byte = 8'hFF;
    case (byte_idx_reg)
      3'd0:    tx_byte = 8'hFF;
      3'd1:    tx_byte = 8'h41;
      3'd2:    tx_byte = 8'h5A;
      3'd3:    tx_byte = snap_reg[7:0];
      default: tx_byte = snap_reg[15:8];
    endcase
  end

  // Received byte including the bit arriving on this rise strobe, and the header check on it.
  always_comb begin
    rx_full          = rx_byte_reg;
    rx_full[bit_cnt_reg] = cmd_bit;
    header_bad = ((byte_idx_reg == 3'd0) && (rx_full != 8'h01)) ||
                 ((byte_idx_reg == 3'd1) && (rx_full != 8'h42));
  end

  // Next-state and output logic; an ATT rise overrides every other event.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_idx_next  = byte_idx_reg;
    rx_byte_next   = rx_byte_reg;
    snap_next      = snap_reg;
    cnt_next       = cnt_reg;
    dat_next       = dat_reg;
    ack_n_next     = ack_n_reg;
    poll_done_next = 1'b0;

    if (att_rise) begin
      state_next    = S_IDLE;
      bit_cnt_next  = 3'd0;
      byte_idx_next = 3'd0;
      cnt_next      = '0;
      dat_next      = 1'b1;
      ack_n_next    = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          dat_next   = 1'b1;
          ack_n_next = 1'b1;
          if (att_fall) begin
            state_next    = S_SHIFT;
            snap_next     = pad_buttons;
            bit_cnt_next  = 3'd0;
            byte_idx_next = 3'd0;
            dat_next      = 1'b1;
          end
        end

        S_SHIFT: begin
          if (clk_rise) begin
            rx_byte_next = rx_full;
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next = 3'd0;
              if (header_bad) begin
                state_next = S_IGNORE;
                dat_next   = 1'b1;
              end else if (byte_idx_reg == 3'd4) begin
                state_next     = S_IGNORE;
                dat_next       = 1'b1;
                poll_done_next = 1'b1;
              end else begin
                byte_idx_next = byte_idx_reg + 3'd1;
                cnt_next      = CNT_ONE;
                if (ACK_DELAY == 1) begin
                  state_next = S_ACK_LOW;
                  ack_n_next = 1'b0;
                end else begin
                  state_next = S_ACK_WAIT;
                end
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else if (clk_fall) begin
            dat_next = tx_byte[bit_cnt_reg];
          end
        end

        S_ACK_WAIT, S_ACK_LOW: begin
          if (clk_fall) begin
            // Host did not wait for ACK: drop the pulse and treat this as bit 0 of the next byte.
            state_next = S_SHIFT;
            ack_n_next = 1'b1;
            cnt_next   = '0;
            dat_next   = tx_byte[bit_cnt_reg];
          end else if (state_reg == S_ACK_WAIT) begin
            if (cnt_reg == DELAY_LAST) begin
              state_next = S_ACK_LOW;
              ack_n_next = 1'b0;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end else begin
            if (cnt_reg == WIDTH_LAST) begin
              state_next = S_SHIFT;
              ack_n_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
        end

        S_IGNORE: begin
          dat_next   = 1'b1;
          ack_n_next = 1'b1;
        end

        default: begin
          state_next = S_IDLE;
          dat_next   = 1'b1;
          ack_n_next = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 3'd0;
      byte_idx_reg  <= 3'd0;
      rx_byte_reg   <= 8'h00;
      snap_reg      <= 16'hFFFF;
      cnt_reg       <= '0;
      dat_reg       <= 1'b1;
      ack_n_reg     <= 1'b1;
      poll_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_idx_reg  <= byte_idx_next;
      rx_byte_reg   <= rx_byte_next;
      snap_reg      <= snap_next;
      cnt_reg       <= cnt_next;
      dat_reg       <= dat_next;
      ack_n_reg     <= ack_n_next;
      poll_done_reg <= poll_done_next;
    end
  end

  assign psx_dat   = dat_reg;
  assign psx_ack_n = ack_n_reg;
  assign poll_done = poll_done_reg;

endmodule

// File: tb/tb_dualshock_responder.sv
// Testbench for dualshock_responder: acts as the host, clocks poll bytes in and
// compares every reply byte, ACK pulse and poll_done pulse against a reference model.
module tb_dualshock_responder;
  localparam int D       = 100;
  localparam int W       = 100;
  localparam int HALF    = 6;
  localparam int PATIENT = D + W + 10;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic [15:0] pad_buttons = 16'hFFFF;
  logic        att_n       = 1'b1;
  logic        pclk        = 1'b1;
  logic        cmd         = 1'b1;
  logic        dat;
  logic        ack_n;
  logic        pd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ack_falls[$];
  int ack_widths[$];
  int pd_cycs[$];
  int ack_len     = 0;
  logic ack_prev  = 1'b1;

  dualshock_responder #(.ACK_DELAY(D), .ACK_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_buttons(pad_buttons),
    .psx_att_n  (att_n),
    .psx_clk    (pclk),
    .psx_cmd    (cmd),
    .psx_dat    (dat),
    .psx_ack_n  (ack_n),
    .poll_done  (pd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records ACK pulse start cycles and widths, and poll_done pulse cycles.
  always @(negedge clk) begin
    if (ack_prev && !ack_n) begin
      ack_falls.push_back(cyc);
      ack_len = 0;
    end
    if (!ack_n) ack_len++;
    if (!ack_prev && ack_n) ack_widths.push_back(ack_len);
    ack_prev = ack_n;
    if (pd) pd_cycs.push_back(cyc);
  end

  // Reference model: reply byte idx of a poll whose first two host bytes are h0, h1.
  function automatic logic [7:0] model_reply(input logic [7:0] h0, input logic [7:0] h1,
                                             input logic [15:0] snap, input int idx);
    if (idx == 0) return 8'hFF;
    if (h0 != 8'h01) return 8'hFF;
    if (idx == 1) return 8'h41;
    if (h1 != 8'h42) return 8'hFF;
    if (idx == 2) return 8'h5A;
    if (idx == 3) return snap[7:0];
    return snap[15:8];
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    ack_falls.delete();
    ack_widths.delete();
    pd_cycs.delete();
  endtask

  // One host byte, LSB first; DAT sampled just before each CLK rise.
  task automatic send_byte(input logic [7:0] c, input int gap, output logic [7:0] r,
                           output int rise_cyc);
    for (int i = 0; i < 8; i++) begin
      pclk = 1'b0;
      cmd  = c[i];
      wait_neg(HALF);
      r[i] = dat;
      pclk = 1'b1;
      if (i == 7) rise_cyc = cyc;
      wait_neg(HALF);
    end
    cmd = 1'b1;
    wait_neg(gap);
  endtask

  // Full 5-byte transaction. A pin edge driven while cyc==c is strobed after two
  // synchronizer stages; the cycle after that strobe is c+3, so poll_done appears at
  // c+3 and the ACK fall, ACK_DELAY cycles after the strobe cycle, at c+2+D.
  task automatic run_poll(input string name, input logic [39:0] cmds, input logic [15:0] btn,
                          input logic [15:0] btn_mid, input int gap0);
    logic [7:0]  rep;
    logic [7:0]  expb;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [39:0] got;
    int rise[5];
    int gap, first, nack, exp_acks, exp_pd;
    h0 = cmds[7:0];
    h1 = cmds[15:8];
    clear_mon();
    pad_buttons = btn;
    att_n = 1'b0;
    wait_neg(2 * HALF);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) pad_buttons = btn_mid;
      gap = (k == 0) ? gap0 : PATIENT;
      send_byte(cmds[8*k +: 8], gap, rep, rise[k]);
      got[8*k +: 8] = rep;
      expb = model_reply(h0, h1, btn, k);
      vectors++;
      if (rep !== expb) begin
        miscompares++;
        $display("FAIL %s reply byte %0d: got %h expected %h", name, k, rep, expb);
      end
    end
    att_n = 1'b1;
    wait_neg(20);

    nack     = (h0 != 8'h01) ? 0 : ((h1 != 8'h42) ? 1 : 4);
    first    = (gap0 < D) ? 1 : 0;
    exp_acks = (nack > first) ? nack - first : 0;
    exp_pd   = (nack == 4) ? 1 : 0;

    vectors++;
    if (ack_falls.size() != exp_acks) begin
      miscompares++;
      $display("FAIL %s ack count: got %0d expected %0d", name, ack_falls.size(), exp_acks);
    end
    for (int j = 0; j < exp_acks && j < ack_falls.size(); j++) begin
      vectors++;
      if (ack_falls[j] - rise[first + j] != D + 2) begin
        miscompares++;
        $display("FAIL %s ack %0d delay: got %0d expected %0d", name, j,
                 ack_falls[j] - rise[first + j], D + 2);
      end
      if (j < ack_widths.size()) begin
        vectors++;
        if (ack_widths[j] != W) begin
          miscompares++;
          $display("FAIL %s ack %0d width: got %0d expected %0d", name, j, ack_widths[j], W);
        end
      end
    end
    vectors++;
    if (pd_cycs.size() != exp_pd) begin
      miscompares++;
      $display("FAIL %s poll_done count: got %0d expected %0d", name, pd_cycs.size(), exp_pd);
    end else if (exp_pd == 1) begin
      vectors++;
      if (pd_cycs[0] - rise[4] != 3) begin
        miscompares++;
        $display("FAIL %s poll_done timing: got %0d expected 3", name, pd_cycs[0] - rise[4]);
      end
    end
    $display("poll %s: cmd %h buttons %h reply %h acks %0d poll_done %0d",
             name, cmds, btn, got, ack_falls.size(), pd_cycs.size());
  endtask

  task automatic test_reset();
    wait_neg(3);
    vectors++;
    if ({dat, ack_n, pd} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset outputs: got %b expected 110", {dat, ack_n, pd});
    end
    rst_n = 1'b1;
    wait_neg(10);
    vectors++;
    if ({dat, ack_n, pd} !== 3'b110) begin
      miscompares++;
      $display("FAIL idle outputs: got %b expected 110", {dat, ack_n, pd});
    end
    $display("reset: outputs dat=%b ack_n=%b poll_done=%b", dat, ack_n, pd);
  endtask

  task automatic test_full_poll();
    run_poll("full_poll", 40'h00_00_00_42_01, 16'hFFFF, 16'hFFFF, PATIENT);
  endtask

  task automatic test_buttons();
    run_poll("buttons", 40'h00_00_00_42_01, 16'hBFF7, 16'h0000, PATIENT);
  endtask

  task automatic test_bad_header();
    run_poll("bad_header", 40'h00_00_00_42_81, 16'h1234, 16'h1234, PATIENT);
    run_poll("bad_second", 40'h00_00_00_43_01, 16'h1234, 16'h1234, PATIENT);
    run_poll("after_bad", 40'h00_00_00_42_01, 16'h5AA5, 16'h5AA5, PATIENT);
  endtask

  task automatic test_impatient();
    run_poll("impatient", 40'h00_00_00_42_01, 16'hFFFF, 16'hFFFF, 10);
  endtask

  task automatic test_early_release();
    logic [7:0]  rep;
    logic [15:0] btn;
    int r;
    clear_mon();
    btn = 16'($urandom);
    pad_buttons = btn;
    att_n = 1'b0;
    wait_neg(2 * HALF);
    send_byte(8'h01, PATIENT, rep, r);
    send_byte(8'h42, PATIENT, rep, r);
    vectors++;
    if (rep !== 8'h41) begin
      miscompares++;
      $display("FAIL early_release byte 1: got %h expected 41", rep);
    end
    send_byte(8'($urandom), D + 2 + 20, rep, r);
    vectors++;
    if (rep !== 8'h5A) begin
      miscompares++;
      $display("FAIL early_release byte 2: got %h expected 5a", rep);
    end
    vectors++;
    if (ack_n !== 1'b0) begin
      miscompares++;
      $display("FAIL early_release in ack_low: got ack_n=%b expected 0", ack_n);
    end
    att_n = 1'b1;
    wait_neg(4);
    vectors++;
    if ({ack_n, dat} !== 2'b11) begin
      miscompares++;
      $display("FAIL early_release outputs: got ack_n,dat=%b expected 11", {ack_n, dat});
    end
    wait_neg(W + 20);
    vectors++;
    if (pd_cycs.size() != 0) begin
      miscompares++;
      $display("FAIL early_release poll_done: got %0d expected 0", pd_cycs.size());
    end
    $display("poll early_release: buttons %h acks %0d poll_done %0d",
             btn, ack_falls.size(), pd_cycs.size());
  endtask

  task automatic test_random();
    logic [39:0] cmds;
    logic [15:0] btn;
    logic [15:0] btn_mid;
    int gap0;
    for (int i = 0; i < 6; i++) begin
      btn     = 16'($urandom);
      btn_mid = 16'($urandom);
      cmds    = {8'($urandom), 8'($urandom), 8'($urandom), 8'h42, 8'h01};
      if ($urandom_range(0, 4) == 0) cmds[7:0]  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) cmds[15:8] = 8'($urandom);
      gap0 = ($urandom_range(0, 1) == 1) ? 10 : PATIENT;
      run_poll("random", cmds, btn, btn_mid, gap0);
    end
  endtask

  task automatic test_back_to_back();
    run_poll("b2b_a", 40'hA5_5A_00_42_01, 16'h0F0F, 16'hFFFF, PATIENT);
    run_poll("b2b_b", 40'h00_FF_11_42_01, 16'hF0F0, 16'h0000, PATIENT);
  endtask

  task automatic test_async_reset();
    logic [7:0] rep;
    int r;
    clear_mon();
    pad_buttons = 16'h0000;
    att_n = 1'b0;
    wait_neg(2 * HALF);
    send_byte(8'h01, PATIENT, rep, r);
    send_byte(8'h42, PATIENT, rep, r);
    send_byte(8'h00, PATIENT, rep, r);
    for (int i = 0; i < 3; i++) begin
      pclk = 1'b0;
      cmd  = 1'b0;
      wait_neg(HALF);
      pclk = 1'b1;
      wait_neg(HALF);
    end
    pclk = 1'b0;
    wait_neg(HALF);
    vectors++;
    if (dat !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset byte 3 bit 3: got %b expected 0", dat);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dat, ack_n, pd} !== 3'b110) begin
      miscompares++;
      $display("FAIL async_reset outputs: got %b expected 110", {dat, ack_n, pd});
    end
    wait_neg(3);
    pclk = 1'b1;
    wait_neg(HALF);
    rst_n = 1'b1;
    wait_neg(HALF);
    clear_mon();
    send_byte(8'h01, 20, rep, r);
    vectors++;
    if (rep !== 8'hFF) begin
      miscompares++;
      $display("FAIL post_reset byte 0: got %h expected ff", rep);
    end
    send_byte(8'h42, 20, rep, r);
    vectors++;
    if (rep !== 8'hFF) begin
      miscompares++;
      $display("FAIL post_reset byte 1: got %h expected ff", rep);
    end
    vectors++;
    if (ack_falls.size() != 0 || pd_cycs.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset activity: got acks=%0d poll_done=%0d expected 0 0",
               ack_falls.size(), pd_cycs.size());
    end
    $display("async_reset: no response while ATT held low through reset release");
    att_n = 1'b1;
    wait_neg(20);
    run_poll("after_reset", 40'h00_00_00_42_01, 16'h7E81, 16'h7E81, PATIENT);
  endtask

  initial begin
    test_reset();
    test_full_poll();
    test_buttons();
    test_bad_header();
    test_early_release();
    test_impatient();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: got time limit reached expected bench completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
